// File: rtl/pmesh_nc_store_packetizer_pkg.sv
// ---------------------------------------------------------------------------
// pmesh_nc_store_packetizer_pkg
//   Shared P-Mesh definitions for the non-cacheable store packetizer:
//   message type / data size codes, NoC1 flit field positions, the
//   packetizer FSM encoding and small helpers used by the top and the
//   data-replication sub-module.
// ---------------------------------------------------------------------------
package pmesh_nc_store_packetizer_pkg;

    // Message type and length of an NC store request (3 flits after header)
    localparam logic [7:0] MSG_TYPE_NC_STORE_REQ = 8'd34;
    localparam logic [7:0] NC_STORE_MSG_LEN      = 8'd3;

    // MSG_DATA_SIZE encoding
    localparam logic [2:0] MSG_DATA_SIZE_0B = 3'b000;
    localparam logic [2:0] MSG_DATA_SIZE_1B = 3'b001;
    localparam logic [2:0] MSG_DATA_SIZE_2B = 3'b010;
    localparam logic [2:0] MSG_DATA_SIZE_4B = 3'b011;
    localparam logic [2:0] MSG_DATA_SIZE_8B = 3'b100;

    // Routing fields shared by the header and source flits
    localparam int FLIT_CHIPID_LSB = 50;
    localparam int FLIT_X_LSB      = 42;
    localparam int FLIT_Y_LSB      = 34;
    localparam int FLIT_FBITS_LSB  = 30;

    // Header-only fields
    localparam int HDR_LEN_LSB  = 22;
    localparam int HDR_TYPE_LSB = 14;
    localparam int HDR_MSHR_LSB = 6;

    // Address flit fields
    localparam int ADDR_SIZE_LSB = 40;

    // Packetizer FSM: one state per outgoing flit plus IDLE
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_ADDR = 3'd2,
        ST_SRC  = 3'd3,
        ST_DATA = 3'd4
    } pkt_state_e;

    function automatic logic size_legal(input logic [2:0] size);
        return (size == MSG_DATA_SIZE_1B) || (size == MSG_DATA_SIZE_2B) ||
               (size == MSG_DATA_SIZE_4B) || (size == MSG_DATA_SIZE_8B);
    endfunction

    // Offset bits that must be zero for a naturally aligned chunk.
    // Illegal sizes are handled as 8B, so they get the 8B mask.
    function automatic logic [2:0] align_mask(input logic [2:0] size);
        logic [2:0] m;
        case (size)
            MSG_DATA_SIZE_1B: m = 3'b000;
            MSG_DATA_SIZE_2B: m = 3'b001;
            MSG_DATA_SIZE_4B: m = 3'b011;
            default:          m = 3'b111;
        endcase
        return m;
    endfunction

    // Chip/x/y/fbits routing block common to header and source flits
    function automatic logic [63:0] route_flit(input logic [13:0] chipid,
                                               input logic [7:0]  x,
                                               input logic [7:0]  y,
                                               input logic [3:0]  fbits);
        logic [63:0] f;
        f = '0;
        f[FLIT_CHIPID_LSB +: 14] = chipid;
        f[FLIT_X_LSB      +: 8]  = x;
        f[FLIT_Y_LSB      +: 8]  = y;
        f[FLIT_FBITS_LSB  +: 4]  = fbits;
        return f;
    endfunction

endpackage

// File: rtl/pmesh_store_data_replicate.sv
// ---------------------------------------------------------------------------
// pmesh_store_data_replicate
//   Combinational data-flit builder. Selects the bytes addressed by
//   size/offset from a 64-bit beat (byte 0 in the MSB lane) and replicates
//   them across the whole flit.
//   Ports:
//     size   - MSG_DATA_SIZE code (illegal codes behave as 8B)
//     offset - byte offset in the 8-byte word, truncated to size alignment
//     data   - write beat
//     flit   - replicated data flit
// ---------------------------------------------------------------------------
module pmesh_store_data_replicate
    import pmesh_nc_store_packetizer_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [2:0]  offset,
    input  logic [63:0] data,
    output logic [63:0] flit
);

    logic [2:0]  base;
    logic [63:0] shifted;

    // Misaligned offsets round down to the size boundary
    assign base    = offset & ~align_mask(size);
    // Move the addressed byte to the MSB lane so every size reads from the top
    assign shifted = data << {base, 3'b000};

    always_comb begin
        flit = data;
        case (size)
            MSG_DATA_SIZE_1B: flit = {8{shifted[63:56]}};
            MSG_DATA_SIZE_2B: flit = {4{shifted[63:48]}};
            MSG_DATA_SIZE_4B: flit = {2{shifted[63:32]}};
            default:          flit = data;
        endcase
    end

endmodule

// File: rtl/pmesh_nc_store_packetizer.sv
// ---------------------------------------------------------------------------
// pmesh_nc_store_packetizer
//   Turns one aligned store chunk into a 4-flit P-Mesh NC store request on
//   NoC1, tracks outstanding stores against acks, hands out MSHR IDs and
//   flags malformed chunks.
//   Ports:
//     clk, rst            - clock, synchronous active-high reset
//     s_valid/s_ready     - chunk handshake; s_addr/s_data/s_size/s_offset
//     dst_*, src_*        - routing IDs, captured with the chunk
//     noc_valid/noc_ready - NoC1 flit handshake; noc_data is the flit
//     ack_valid           - one pulse per NC store ack
//     outstanding         - stores in flight
//     idle                - FSM idle and nothing outstanding
//     err_misalign        - sticky: misaligned offset or illegal size
//     err_ack             - sticky: ack with nothing outstanding
// ---------------------------------------------------------------------------
module pmesh_nc_store_packetizer
    import pmesh_nc_store_packetizer_pkg::*;
#(
    parameter int         MAX_OUTSTANDING = 8,
    parameter int         MSHRID_W        = 8,
    parameter logic [3:0] FBITS           = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [39:0] s_addr,
    input  logic [63:0] s_data,
    input  logic [2:0]  s_size,
    input  logic [5:0]  s_offset,
    input  logic [13:0] dst_chipid,
    input  logic [7:0]  dst_x,
    input  logic [7:0]  dst_y,
    input  logic [13:0] src_chipid,
    input  logic [7:0]  src_x,
    input  logic [7:0]  src_y,
    output logic        noc_valid,
    input  logic        noc_ready,
    output logic [63:0] noc_data,
    input  logic        ack_valid,
    output logic [7:0]  outstanding,
    output logic        idle,
    output logic        err_misalign,
    output logic        err_ack
);

    localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

    pkt_state_e          state_q, state_d;
    logic [MSHRID_W-1:0] mshr_q;
    logic [7:0]          out_q;
    logic                err_mis_q, err_ack_q;
    logic                accept;

    // Flits are fully formed at accept time so noc_data is a plain register
    // mux and cannot move while the NoC stalls.
    logic [63:0] hdr_q,  addr_q,  src_q,  data_q;
    logic [63:0] hdr_d,  addr_d,  src_d,  data_d;

    logic        chunk_bad;

    // Address LSBs and upper offset bits carry no information here
    logic unused_bits;
    assign unused_bits = ^{s_addr[2:0], s_offset[5:3]};

    // ------------------------------------------------------------------
    // Flit construction from the live inputs (registered on accept)
    // ------------------------------------------------------------------
    pmesh_store_data_replicate u_repl (
        .size   (s_size),
        .offset (s_offset[2:0]),
        .data   (s_data),
        .flit   (data_d)
    );

    always_comb begin
        hdr_d = route_flit(dst_chipid, dst_x, dst_y, FBITS);
        hdr_d[HDR_LEN_LSB  +: 8] = NC_STORE_MSG_LEN;
        hdr_d[HDR_TYPE_LSB +: 8] = MSG_TYPE_NC_STORE_REQ;
        hdr_d[HDR_MSHR_LSB +: 8] = 8'(mshr_q);

        addr_d = '0;
        addr_d[39:0]                = {s_addr[39:3], s_offset[2:0]};
        addr_d[ADDR_SIZE_LSB +: 3]  = s_size;

        src_d = route_flit(src_chipid, src_x, src_y, FBITS);
    end

    assign chunk_bad = !size_legal(s_size) ||
                       ((s_offset[2:0] & align_mask(s_size)) != 3'b000);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        s_ready   = 1'b0;
        noc_valid = 1'b0;
        noc_data  = '0;
        case (state_q)
            ST_IDLE: begin
                // Gated with rst so the source never sees a handshake while
                // the block is being reset.
                s_ready = !rst && (out_q < MAX_OUT);
                if (s_valid && s_ready) state_d = ST_HDR;
            end
            ST_HDR: begin
                noc_valid = 1'b1;
                noc_data  = hdr_q;
                if (noc_ready) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                noc_valid = 1'b1;
                noc_data  = addr_q;
                if (noc_ready) state_d = ST_SRC;
            end
            ST_SRC: begin
                noc_valid = 1'b1;
                noc_data  = src_q;
                if (noc_ready) state_d = ST_DATA;
            end
            ST_DATA: begin
                noc_valid = 1'b1;
                noc_data  = data_q;
                if (noc_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept = s_valid && s_ready;

    // ------------------------------------------------------------------
    // Chunk capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            hdr_q  <= hdr_d;
            addr_q <= addr_d;
            src_q  <= src_d;
            data_q <= data_d;
        end
    end

    // ------------------------------------------------------------------
    // MSHR IDs, outstanding count, error flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mshr_q    <= '0;
            out_q     <= '0;
            err_mis_q <= 1'b0;
            err_ack_q <= 1'b0;
        end else begin
            if (accept) begin
                mshr_q <= mshr_q + 1'b1;
                if (chunk_bad) err_mis_q <= 1'b1;
            end
            // An ack with nothing outstanding cannot belong to a chunk
            // accepted in the same cycle, so it is flagged either way.
            if (ack_valid && out_q == 8'd0) err_ack_q <= 1'b1;
            case ({accept, ack_valid})
                2'b10:   out_q <= out_q + 8'd1;
                2'b01:   if (out_q != 8'd0) out_q <= out_q - 8'd1;
                default: out_q <= out_q;
            endcase
        end
    end

    assign outstanding  = out_q;
    assign idle         = (state_q == ST_IDLE) && (out_q == 8'd0);
    assign err_misalign = err_mis_q;
    assign err_ack      = err_ack_q;

endmodule
